// File: rtl/pe_feeder.sv
// pe_feeder: sequences one job of sample groups into a PE chain.
//   clk, reset (sync, active-low)
//   cmd_valid/cmd_ready, cmd_channel_packed, cmd_num_groups : job request
//   in_valid/in_ready, in_img, in_weight3..1                 : sample stream
//   pe_start, pe_reset, pe_img, pe_weight3..1, pe_channel_packed : PE chain bus
//   busy, done (pulse), underrun (sticky until next accept)
module pe_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_channel_packed,
  input  logic [15:0] cmd_num_groups,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_img,
  input  logic [7:0]  in_weight3,
  input  logic [7:0]  in_weight2,
  input  logic [7:0]  in_weight1,
  output logic        pe_start,
  output logic        pe_reset,
  output logic [7:0]  pe_img,
  output logic [7:0]  pe_weight3,
  output logic [7:0]  pe_weight2,
  output logic [7:0]  pe_weight1,
  output logic [2:0]  pe_channel_packed,
  output logic        busy,
  output logic        done,
  output logic        underrun
);
  typedef enum logic [2:0] {IDLE, CLR, WAIT, STREAM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] chan_q, chan_d;
  logic [15:0] ngrp_q, ngrp_d, grp_q, grp_d;
  logic [9:0] cnt_q, cnt_d, size;
  logic [1:0] sub_q, sub_d;
  logic und_q, und_d, abort, xfer;
  logic pe_start_q, pe_reset_q;
  logic [31:0] pe_data_q, pe_data_d;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign in_ready = state_q == WAIT || state_q == STREAM;
  assign done = state_q == DONE;
  assign underrun = und_q;
  assign pe_channel_packed = chan_q;
  assign pe_start = pe_start_q;
  assign pe_reset = pe_reset_q;
  assign {pe_img, pe_weight3, pe_weight2, pe_weight1} = pe_data_q;
  assign xfer = in_valid && in_ready;
  assign size = chan_q == 3'd0 ? 10'd3 : 10'd1 << ({1'b0, chan_q} + 4'd2);
  // sub_q counts cycles spent in the current state (CLR and DRAIN lengths)
  assign sub_d = state_d == state_q ? sub_q + 2'd1 : 2'd0;
  assign pe_data_d = xfer ? {in_img, in_weight3, in_weight2, in_weight1} : 32'd0;
  always_comb begin
    state_d = state_q;
    chan_d = chan_q;
    ngrp_d = ngrp_q;
    grp_d = grp_q;
    cnt_d = cnt_q;
    und_d = und_q;
    abort = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = CLR;
        chan_d = cmd_channel_packed;
        ngrp_d = cmd_num_groups;
        grp_d = 16'd0;
        cnt_d = 10'd0;
        und_d = 1'b0;
      end
      CLR: if (sub_q == 2'd1) state_d = ngrp_q == 16'd0 ? DONE : WAIT;
      WAIT: if (in_valid) begin
        cnt_d = 10'd1;
        state_d = STREAM;
      end
      STREAM: if (!in_valid) begin
        // the PE chain cannot stall, so a gap inside a group kills the job
        state_d = IDLE;
        und_d = 1'b1;
        abort = 1'b1;
      end else if (cnt_q + 10'd1 == size) begin
        cnt_d = 10'd0;
        grp_d = grp_q + 16'd1;
        state_d = grp_q + 16'd1 == ngrp_q ? DRAIN : WAIT;
      end else cnt_d = cnt_q + 10'd1;
      DRAIN: if (sub_q == 2'd3) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      chan_q <= 3'd0;
      ngrp_q <= 16'd0;
      grp_q <= 16'd0;
      cnt_q <= 10'd0;
      sub_q <= 2'd0;
      und_q <= 1'b0;
      pe_start_q <= 1'b0;
      pe_reset_q <= 1'b0;
      pe_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      chan_q <= chan_d;
      ngrp_q <= ngrp_d;
      grp_q <= grp_d;
      cnt_q <= cnt_d;
      sub_q <= sub_d;
      und_q <= und_d;
      pe_start_q <= xfer && state_q == WAIT;
      // registered from state_d so it is high exactly while state_q is CLR
      pe_reset_q <= state_d == CLR || abort;
      pe_data_q <= pe_data_d;
    end
  end
endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 The module SHALL have ports `clk` (in, 1): the single clock; all state changes on the rising edge.
REQ-002 The module SHALL have port `reset` (in, 1): synchronous, active-low; 0 sampled at a clk edge resets the block.
REQ-003 The module SHALL have ports `cmd_valid` (in, 1) and `cmd_ready` (out, 1): job request handshake; a job is accepted on a cycle where both are 1.
REQ-004 The module SHALL have ports `cmd_channel_packed` (in, 3) and `cmd_num_groups` (in, 16): channel code and count of output pixels (groups) for the job; both captured on accept.
REQ-005 The module SHALL have ports `in_valid` (in, 1) and `in_ready` (out, 1): sample stream handshake; a sample transfers when both are 1.
REQ-006 The module SHALL have ports `in_img`, `in_weight3`, `in_weight2`, `in_weight1` (in, 8 each): one sample of image and per-row weights.
REQ-007 The module SHALL have ports `pe_start` and `pe_reset` (out, 1 each): active-high PE chain controls.
REQ-008 The module SHALL have ports `pe_img`, `pe_weight3`, `pe_weight2`, `pe_weight1` (out, 8 each): sample bus to the PE chain.
REQ-009 The module SHALL have port `pe_channel_packed` (out, 3): the latched job channel code.
REQ-010 The module SHALL have ports `busy` (out, 1), `done` (out, 1, one-cycle pulse), and `underrun` (out, 1, sticky until next accept).

Function
REQ-011 Channel size SHALL decode from the latched code as 0->3, 1->8, 2->16, 3->32, 4->64, 5->128, 6->256, 7->512, using a 10-bit counter compare.
REQ-012 The FSM SHALL have states IDLE, CLR, WAIT, STREAM, DRAIN and DONE.
REQ-013 In IDLE, `cmd_ready` SHALL be 1, `busy` SHALL be 0, and `in_ready` SHALL be 0; on accept, the FSM SHALL latch the fields, clear `underrun`, and go to CLR.
REQ-014 In CLR, `pe_reset` SHALL be 1 for exactly 2 consecutive cycles, then the FSM SHALL go to WAIT; if num_groups==0 it SHALL go to DONE instead.
REQ-015 In WAIT, `in_ready` SHALL be 1; the FSM SHALL stay in WAIT while `in_valid`=0. The first transferred sample SHALL appear on the pe_* buses the next cycle with `pe_start`=1, sample count 1, and the FSM SHALL go to STREAM.
REQ-016 In STREAM, `in_ready` SHALL be 1; each transferred sample SHALL drive the pe_* buses one cycle later with `pe_start`=0. When the count reaches channel size, the group count SHALL increment and the FSM SHALL go to WAIT, or to DRAIN if it was the last group.
REQ-017 Samples within a group SHALL be contiguous, since the PE chain has no stall. If `in_valid`=0 in STREAM, the block SHALL set `underrun`=1, drive `pe_reset`=1 for 1 cycle, raise no `done`, and return to IDLE.
REQ-018 On any cycle without a transfer (IDLE, CLR, WAIT idle, DRAIN, DONE), the pe_* data buses and `pe_start` SHALL be 0.
REQ-019 DRAIN SHALL last exactly 4 cycles (PE pipeline depth plus output register), then go to DONE.
REQ-020 DONE SHALL pulse `done`=1 for one cycle and return to IDLE.
REQ-021 `busy` SHALL be 1 in every state except IDLE.
REQ-022 `cmd_ready` SHALL be 0 when not in IDLE, so `cmd_valid` while busy is ignored and not queued.
REQ-023 `pe_channel_packed` SHALL hold the latched code from accept until the next accept.
REQ-024 The group counter SHALL be 16-bit with no wrap: num_groups=65535 completes normally.

Reset
REQ-025 With `reset`=0 at a clk edge, the FSM SHALL go to IDLE, all counters SHALL clear, and all outputs SHALL be 0 except `cmd_ready`=1.
REQ-026 Reset mid-STREAM SHALL abort without `done` or `underrun`, and `pe_reset` SHALL be 0 during reset.
REQ-027 The first post-reset cycle SHALL accept a command.

Verification
REQ-028 Job code 0, 2 groups, `in_valid` held 1 -> `pe_reset` high 2 cycles, then pe_start pulses 3 cycles apart on samples 1 and 4, 6 samples out, `done` 4 cycles after the last sample.
REQ-029 Code 7, 1 group, with `in_valid` low for 5 cycles before the group -> stays in WAIT, then 512 contiguous samples, `pe_start` only on the first.
REQ-030 Code 1, `in_valid` dropped at sample 5 -> `underrun`=1, one-cycle `pe_reset`, no `done`, back to IDLE (`cmd_ready`=1).
REQ-031 num_groups=0 -> 2-cycle `pe_reset`, then `done` with no pe_start and `in_ready` never 1.
REQ-032 `cmd_valid` asserted while busy, and `reset`=0 mid-STREAM -> second command ignored; after reset all outputs are 0, `cmd_ready`=1, and a new job runs correctly.
REQ-033 Data integrity: incrementing in_img/weights pattern -> pe_* buses equal the inputs delayed by exactly 1 cycle in every group.
